uart_tx_feeder: RTL and testbench



---
 rtl/uart_tx_feeder.sv | 169 ++++++++++++++++
 tb/tb_uart_tx_feeder.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_feeder.sv
// Byte FIFO and transmit sequencer feeding a UART transmitter.
// Each byte is released only after the transmitter's Active/Done handshake completes.
module uart_tx_feeder #(
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic [DATA_WIDTH-1:0] WrData,
    input  logic                  WrValid,
    output logic                  WrReady,
    input  logic                  ClearErr,
    output logic                  Full,
    output logic                  Empty,
    output logic [ADDR_WIDTH:0]   Count,
    output logic                  Overflow,
    output logic [DATA_WIDTH-1:0] TxData,
    output logic                  TxSend,
    input  logic                  TxActive,
    input  logic                  TxDone,
    output logic                  Busy
);

    localparam int unsigned COUNT_WIDTH = ADDR_WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD      = 2'd1,
        SEND      = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t                  state;
    state_t                  nextState;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [ADDR_WIDTH-1:0]   wrPtr;
    logic [ADDR_WIDTH-1:0]   rdPtr;
    logic                    push;
    logic                    pop;
    logic                    txDonePrev;
    logic                    doneRise;
    logic                    sendNext;
    logic                    busyNext;

    // Flags come straight from the registered count, so a pop never frees a slot in the same cycle.
    assign Full     = (Count == COUNT_WIDTH'(DEPTH));
    assign Empty    = (Count == '0);
    assign WrReady  = !Full;
    assign push     = WrValid && WrReady;
    assign doneRise = TxDone && !txDonePrev;

    always_ff @(posedge Clock) begin
        if (push) begin
            mem[wrPtr] <= WrData;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            if (push) begin
                wrPtr <= wrPtr + ADDR_WIDTH'(1);
            end
            if (pop) begin
                rdPtr <= rdPtr + ADDR_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            Count <= '0;
        end else begin
            case ({push, pop})
                2'b10:   Count <= Count + COUNT_WIDTH'(1);
                2'b01:   Count <= Count - COUNT_WIDTH'(1);
                default: Count <= Count;
            endcase
        end
    end

    // Sticky overflow; a new overflow in the same cycle as a clear keeps the flag set.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            Overflow <= 1'b0;
        end else if (WrValid && Full) begin
            Overflow <= 1'b1;
        end else if (ClearErr) begin
            Overflow <= 1'b0;
        end
    end

    // Reset to 1 so a DoneFlag already high out of reset is not mistaken for a completion.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            txDonePrev <= 1'b1;
        end else begin
            txDonePrev <= TxDone;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (!Empty) begin
                    nextState = LOAD;
                end
            end
            LOAD: begin
                nextState = SEND;
            end
            SEND: begin
                if (TxActive) begin
                    nextState = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (doneRise) begin
                    nextState = IDLE;
                end
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    always_comb begin
        pop      = 1'b0;
        sendNext = 1'b0;
        busyNext = (nextState != IDLE);
        if (state == LOAD) begin
            pop = 1'b1;
        end
        if (nextState == SEND) begin
            sendNext = 1'b1;
        end
    end

    // TxData only changes on the LOAD cycle, holding the byte steady through the handshake.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            TxSend <= 1'b0;
            Busy   <= 1'b0;
            TxData <= '0;
        end else begin
            TxSend <= sendNext;
            Busy   <= busyNext;
            if (pop) begin
                TxData <= mem[rdPtr];
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Self-checking bench for uart_tx_feeder with a queue scoreboard of written bytes
// and a simple transmitter model acknowledging Send after a fixed latency.
module tb_uart_tx_feeder;

    logic       Clock = 1'b0;
    logic       Reset;
    logic [7:0] WrData;
    logic       WrValid;
    logic       WrReady;
    logic       ClearErr;
    logic       Full;
    logic       Empty;
    logic [4:0] Count;
    logic       Overflow;
    logic [7:0] TxData;
    logic       TxSend;
    logic       TxActive;
    logic       TxDone;
    logic       Busy;

    logic       autoAck;
    logic [1:0] sendHist = '0;
    logic [7:0] expQ [$];
    logic [7:0] lastData;
    int         checks   = 0;
    int         failures = 0;

    uart_tx_feeder #(.DEPTH(16), .ADDR_WIDTH(4), .DATA_WIDTH(8)) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .WrData   (WrData),
        .WrValid  (WrValid),
        .WrReady  (WrReady),
        .ClearErr (ClearErr),
        .Full     (Full),
        .Empty    (Empty),
        .Count    (Count),
        .Overflow (Overflow),
        .TxData   (TxData),
        .TxSend   (TxSend),
        .TxActive (TxActive),
        .TxDone   (TxDone),
        .Busy     (Busy)
    );

    always #5 Clock = ~Clock;

    // Transmitter model: Active is seen by the feeder on the third edge with Send high.
    always @(posedge Clock) sendHist <= {sendHist[0], TxSend};
    assign TxActive = autoAck & sendHist[1];

    task automatic do_reset(input logic doneLevel);
        Reset    = 1'b1;
        WrValid  = 1'b0;
        WrData   = 8'h00;
        ClearErr = 1'b0;
        TxDone   = doneLevel;
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        Reset = 1'b0;
        expQ.delete();
    endtask

    task automatic write_byte(input logic [7:0] d, input logic accept);
        WrData  = d;
        WrValid = 1'b1;
        checks++;
        if (WrReady !== accept) begin
            failures++;
            $display("FAIL wr_ready (data %02h): got %b expected %b", d, WrReady, accept);
        end
        if (accept) expQ.push_back(d);
        @(posedge Clock);
        @(negedge Clock);
        WrValid = 1'b0;
    endtask

    // Waits for Send, checks the byte against the scoreboard and the Send pulse length.
    task automatic wait_send(input int expSend);
        int n;
        logic [7:0] exp;
        n = 0;
        while (TxSend !== 1'b1 && n < 64) begin
            @(negedge Clock);
            n++;
        end
        checks++;
        if (TxSend !== 1'b1) begin
            failures++;
            $display("FAIL send_timeout: TxSend got %b expected 1", TxSend);
            return;
        end
        checks++;
        if (expQ.size() == 0) begin
            failures++;
            $display("FAIL unexpected_send: TxData got %02h expected no frame", TxData);
            return;
        end
        exp = expQ.pop_front();
        lastData = exp;
        if (TxData !== exp) begin
            failures++;
            $display("FAIL tx_data: got %02h expected %02h", TxData, exp);
        end
        n = 0;
        while (TxSend === 1'b1 && n < 64) begin
            n++;
            @(negedge Clock);
        end
        checks++;
        if (TxSend !== 1'b0) begin
            failures++;
            $display("FAIL send_release: TxSend got %b expected 0", TxSend);
        end
        if (expSend != 0) begin
            checks++;
            if (n != expSend) begin
                failures++;
                $display("FAIL send_cycles: got %0d expected %0d", n, expSend);
            end
        end
    endtask

    // Drives a fresh low->high DoneFlag; checks the idle gap and, if more data waits, the LOAD cycle.
    task automatic pulse_done(input logic more);
        TxDone = 1'b0;
        @(posedge Clock);
        @(negedge Clock);
        TxDone = 1'b1;
        @(posedge Clock);
        @(negedge Clock);
        checks++;
        if (Busy !== 1'b0) begin
            failures++;
            $display("FAIL busy_after_done: got %b expected 0", Busy);
        end
        TxDone = 1'b0;
        @(negedge Clock);
        checks++;
        if (Busy !== more) begin
            failures++;
            $display("FAIL next_load_busy: got %b expected %b", Busy, more);
        end
        if (more) begin
            checks++;
            if (TxSend !== 1'b0 || TxData !== lastData) begin
                failures++;
                $display("FAIL load_cycle: TxSend %b TxData %02h expected 0 %02h", TxSend, TxData, lastData);
            end
        end
    endtask

    task automatic test_reset();
        do_reset(1'b0);
        checks++;
        if (Count !== 5'd0 || Empty !== 1'b1 || Full !== 1'b0 || WrReady !== 1'b1 || Overflow !== 1'b0) begin
            failures++;
            $display("FAIL reset_fifo: Count %0d Empty %b Full %b WrReady %b Overflow %b expected 0 1 0 1 0",
                     Count, Empty, Full, WrReady, Overflow);
        end
        checks++;
        if (TxData !== 8'h00 || TxSend !== 1'b0 || Busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_tx: TxData %02h TxSend %b Busy %b expected 00 0 0", TxData, TxSend, Busy);
        end
    endtask

    task automatic test_single();
        do_reset(1'b0);
        autoAck = 1'b1;
        write_byte(8'hA5, 1'b1);
        checks++;
        if (Busy !== 1'b0 || Count !== 5'd1) begin
            failures++;
            $display("FAIL single_written: Busy %b Count %0d expected 0 1", Busy, Count);
        end
        @(negedge Clock);
        checks++;
        if (Busy !== 1'b1 || TxSend !== 1'b0) begin
            failures++;
            $display("FAIL single_load: Busy %b TxSend %b expected 1 0", Busy, TxSend);
        end
        wait_send(3);
        pulse_done(1'b0);
        checks++;
        if (Empty !== 1'b1) begin
            failures++;
            $display("FAIL single_empty: got %b expected 1", Empty);
        end
    endtask

    task automatic test_overflow();
        do_reset(1'b0);
        autoAck = 1'b0;
        for (int i = 0; i < 16; i++) write_byte(8'(i), 1'b1);
        checks++;
        if (Count !== 5'd15 || TxSend !== 1'b1 || Busy !== 1'b1) begin
            failures++;
            $display("FAIL fill_state: Count %0d TxSend %b Busy %b expected 15 1 1", Count, TxSend, Busy);
        end
        write_byte(8'h10, 1'b1);
        write_byte(8'h11, 1'b0);
        checks++;
        if (Full !== 1'b1 || WrReady !== 1'b0 || Overflow !== 1'b1 || Count !== 5'd16) begin
            failures++;
            $display("FAIL overflow_flags: Full %b WrReady %b Overflow %b Count %0d expected 1 0 1 16",
                     Full, WrReady, Overflow, Count);
        end
        TxDone = 1'b1;
        @(posedge Clock);
        @(negedge Clock);
        checks++;
        if (TxSend !== 1'b1 || Busy !== 1'b1) begin
            failures++;
            $display("FAIL done_in_send: TxSend %b Busy %b expected 1 1", TxSend, Busy);
        end
        TxDone = 1'b0;
        ClearErr = 1'b1;
        write_byte(8'h12, 1'b0);
        ClearErr = 1'b0;
        checks++;
        if (Overflow !== 1'b1) begin
            failures++;
            $display("FAIL overflow_set_wins: got %b expected 1", Overflow);
        end
        ClearErr = 1'b1;
        @(posedge Clock);
        @(negedge Clock);
        ClearErr = 1'b0;
        checks++;
        if (Overflow !== 1'b0) begin
            failures++;
            $display("FAIL overflow_clear: got %b expected 0", Overflow);
        end
        autoAck = 1'b1;
        wait_send(0);
        while (expQ.size() > 0) begin
            pulse_done(1'b1);
            wait_send(3);
        end
        pulse_done(1'b0);
    endtask

    task automatic test_back_to_back();
        do_reset(1'b0);
        autoAck = 1'b1;
        write_byte(8'h11, 1'b1);
        write_byte(8'h22, 1'b1);
        write_byte(8'h33, 1'b1);
        wait_send(3);
        pulse_done(1'b1);
        wait_send(3);
        pulse_done(1'b1);
        wait_send(3);
        pulse_done(1'b0);
    endtask

    task automatic test_wrap();
        do_reset(1'b0);
        autoAck = 1'b1;
        write_byte(8'h30, 1'b1);
        wait_send(3);
        for (int i = 0; i < 5; i++) write_byte(8'h31 + 8'(i), 1'b1);
        checks++;
        if (Count !== 5'd5) begin
            failures++;
            $display("FAIL wrap_prefill: Count got %0d expected 5", Count);
        end
        TxDone = 1'b0;
        @(posedge Clock);
        @(negedge Clock);
        TxDone = 1'b1;
        @(posedge Clock);
        @(negedge Clock);
        TxDone = 1'b0;
        @(posedge Clock);
        @(negedge Clock);
        checks++;
        if (Busy !== 1'b1 || TxSend !== 1'b0 || Count !== 5'd5) begin
            failures++;
            $display("FAIL wrap_load: Busy %b TxSend %b Count %0d expected 1 0 5", Busy, TxSend, Count);
        end
        write_byte(8'h36, 1'b1);
        checks++;
        if (Count !== 5'd5) begin
            failures++;
            $display("FAIL push_pop_count: got %0d expected 5", Count);
        end
        wait_send(3);
        for (int i = 0; i < 13; i++) begin
            write_byte(8'h40 + 8'(i), 1'b1);
            pulse_done(1'b1);
            wait_send(3);
        end
        while (expQ.size() > 0) begin
            pulse_done(1'b1);
            wait_send(3);
        end
        pulse_done(1'b0);
        checks++;
        if (Empty !== 1'b1 || Count !== 5'd0) begin
            failures++;
            $display("FAIL wrap_drain: Empty %b Count %0d expected 1 0", Empty, Count);
        end
    endtask

    task automatic test_done_at_reset();
        do_reset(1'b1);
        autoAck = 1'b1;
        write_byte(8'h5A, 1'b1);
        wait_send(3);
        repeat (5) @(negedge Clock);
        checks++;
        if (Busy !== 1'b1 || TxSend !== 1'b0) begin
            failures++;
            $display("FAIL stale_done: Busy %b TxSend %b expected 1 0", Busy, TxSend);
        end
        pulse_done(1'b0);
    endtask

    task automatic test_reset_mid();
        do_reset(1'b0);
        autoAck = 1'b1;
        write_byte(8'h77, 1'b1);
        wait_send(3);
        for (int i = 0; i < 3; i++) write_byte(8'h78 + 8'(i), 1'b1);
        checks++;
        if (Count !== 5'd3 || Busy !== 1'b1) begin
            failures++;
            $display("FAIL mid_setup: Count %0d Busy %b expected 3 1", Count, Busy);
        end
        Reset = 1'b1;
        @(posedge Clock);
        @(negedge Clock);
        checks++;
        if (Count !== 5'd0 || TxSend !== 1'b0 || Busy !== 1'b0 || TxData !== 8'h00 || Empty !== 1'b1) begin
            failures++;
            $display("FAIL mid_reset: Count %0d TxSend %b Busy %b TxData %02h Empty %b expected 0 0 0 00 1",
                     Count, TxSend, Busy, TxData, Empty);
        end
        Reset = 1'b0;
        expQ.delete();
    endtask

    initial begin
        autoAck  = 1'b0;
        lastData = 8'h00;
        test_reset();
        test_single();
        test_overflow();
        test_back_to_back();
        test_wrap();
        test_done_at_reset();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
